// File: rtl/stopwatch_if.sv
// Control/display bundle between the push-button front end and the stopwatch core.
interface stopwatch_if;
  logic       start;
  logic       stop;
  logic [5:0] MM;
  logic [5:0] SS;
  logic       sec_tick;

  modport master (output start, stop, input MM, SS, sec_tick);
  modport slave  (input start, stop, output MM, SS, sec_tick);
endinterface

// File: rtl/stopwatch.sv
// MM:SS stopwatch with an internal seconds prescaler and start/stop control.
// Optional STOPWATCH_SAT_EN: saturate at 59:59, force PAUSE, and ignore start until reset.
module stopwatch #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic        clk,
  input  logic        reset,
  stopwatch_if.slave  bus
);

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] presc;
  logic [5:0]       mm;
  logic [5:0]       ss;
  logic             tick;
  logic             tick_due;
  logic             at_max;
`ifdef STOPWATCH_SAT_EN
  logic             locked;
`endif

  // The RUN flag as registered before the edge gates counting, so a stop
  // sampled on a tick edge still lets that tick land.
  assign tick_due = (state == RUN) && (presc == PRESC_MAX);
  assign at_max   = (mm == 6'd59) && (ss == 6'd59);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PAUSE;
      presc <= '0;
      mm    <= '0;
      ss    <= '0;
      tick  <= 1'b0;
`ifdef STOPWATCH_SAT_EN
      locked <= 1'b0;
`endif
    end else begin
      tick <= 1'b0;

      if (state == RUN) begin
        if (tick_due) begin
          presc <= '0;
          tick  <= 1'b1;
`ifdef STOPWATCH_SAT_EN
          if (!at_max) begin
`else
          begin
`endif
            if (ss == 6'd59) begin
              ss <= '0;
              mm <= at_max ? 6'd0 : mm + 6'd1;
            end else begin
              ss <= ss + 6'd1;
            end
          end
        end else begin
          presc <= presc + CNT_W'(1);
        end
      end

      if (bus.stop) begin
        state <= PAUSE;
`ifdef STOPWATCH_SAT_EN
      end else if (bus.start && (state == PAUSE) && !locked) begin
`else
      end else if (bus.start && (state == PAUSE)) begin
`endif
        state <= RUN;
      end

`ifdef STOPWATCH_SAT_EN
      if (tick_due && at_max) begin
        state  <= PAUSE;
        locked <= 1'b1;
      end
`endif
    end
  end

  assign bus.MM       = mm;
  assign bus.SS       = ss;
  assign bus.sec_tick = tick;

endmodule

// File: tb/tb_stopwatch.sv
// Directed bench for stopwatch: one instance at TICK_DIV=4, one at TICK_DIV=2.
module tb_stopwatch;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  stopwatch_if bus4 ();
  stopwatch_if bus2 ();

  stopwatch #(.TICK_DIV(4), .CNT_W(3)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  stopwatch #(.TICK_DIV(2), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(5);
    reset = 1'b0;
  endtask

  task automatic pulse4(input logic s, input logic p);
    bus4.start = s;
    bus4.stop  = p;
    step(1);
    bus4.start = 1'b0;
    bus4.stop  = 1'b0;
  endtask

  task automatic pulse2(input logic s, input logic p);
    bus2.start = s;
    bus2.stop  = p;
    step(1);
    bus2.start = 1'b0;
    bus2.stop  = 1'b0;
  endtask

  int exp_mm, exp_ss, exp_mm2, exp_ss2;

  initial begin
    bus4.start = 1'b0; bus4.stop = 1'b0;
    bus2.start = 1'b0; bus2.stop = 1'b0;

    // Reset, no start: stays at 00:00 with no ticks
    do_reset();
    for (int i = 0; i < 50; i++) begin
      check("rst_mm", bus4.MM, 0);
      check("rst_ss", bus4.SS, 0);
      check("rst_tick", bus4.sec_tick, 0);
      step(1);
    end

    // Start and count: tick every 4th edge after start
    do_reset();
    pulse4(1'b1, 1'b0);
    for (int k = 1; k <= 148; k++) begin
      step(1);
      check("cnt_tick", bus4.sec_tick, (k % 4 == 0) ? 1 : 0);
      if (k == 3) check("cnt_ss_e3", bus4.SS, 0);
      if (k == 4) check("cnt_ss_e4", bus4.SS, 1);
    end
    check("cnt_ss_148", bus4.SS, 37);
    check("cnt_mm_148", bus4.MM, 0);

    // Pause/resume keeps the partial second
    do_reset();
    pulse4(1'b1, 1'b0);
    step(9);
    pulse4(1'b0, 1'b1);
    check("pause_ss", bus4.SS, 2);
    for (int i = 0; i < 50; i++) begin
      step(1);
      check("pause_tick", bus4.sec_tick, 0);
    end
    check("pause_hold", bus4.SS, 2);
    pulse4(1'b1, 1'b0);
    check("resume_e0", bus4.SS, 2);
    step(1);
    check("resume_e1", bus4.SS, 2);
    step(1);
    check("resume_e2", bus4.SS, 3);
    check("resume_tick", bus4.sec_tick, 1);

    // Simultaneous start+stop: stop wins
    do_reset();
    pulse4(1'b1, 1'b1);
    step(10);
    check("both_pause_ss", bus4.SS, 0);
    pulse4(1'b1, 1'b0);
    step(5);
    check("both_run_ss", bus4.SS, 1);
    pulse4(1'b1, 1'b1);
    step(20);
    check("both_run_hold", bus4.SS, 1);

    // Minute rollover and full-hour wrap at TICK_DIV=2
`ifdef STOPWATCH_SAT_EN
    exp_mm = 59; exp_ss = 59; exp_mm2 = 59; exp_ss2 = 59;
`else
    exp_mm = 0;  exp_ss = 0;  exp_mm2 = 0;  exp_ss2 = 4;
`endif
    do_reset();
    pulse2(1'b1, 1'b0);
    step(120);
    check("roll_mm", bus2.MM, 1);
    check("roll_ss", bus2.SS, 0);
    step(7198 - 120);
    check("pre_wrap_mm", bus2.MM, 59);
    check("pre_wrap_ss", bus2.SS, 59);
    step(1);
    check("pre_wrap_tick", bus2.sec_tick, 0);
    step(1);
    check("wrap_mm", bus2.MM, exp_mm);
    check("wrap_ss", bus2.SS, exp_ss);
    check("wrap_tick", bus2.sec_tick, 1);
    step(4);
    check("post_wrap_mm", bus2.MM, exp_mm);
    check("post_wrap_ss", bus2.SS, (exp_ss2 == 4) ? 2 : 59);
    pulse2(1'b1, 1'b0);
    step(4);
    check("restart_mm", bus2.MM, exp_mm2);
    check("restart_ss", bus2.SS, exp_ss2);

    // Async reset between edges mid-run
    do_reset();
    pulse2(1'b1, 1'b0);
    step(154);
    check("pre_rst_mm", bus2.MM, 1);
    check("pre_rst_ss", bus2.SS, 17);
    #2 reset = 1'b1;
    #1;
    check("arst_mm", bus2.MM, 0);
    check("arst_ss", bus2.SS, 0);
    check("arst_tick", bus2.sec_tick, 0);
    #1 reset = 1'b0;
    step(10);
    check("arst_idle_mm", bus2.MM, 0);
    check("arst_idle_ss", bus2.SS, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
